// File: rtl/jit_pkg.sv
// rtl/jit_pkg.sv - shared constants, beat type and config decode for the jit stream router
//
// Purpose : common definitions imported by jit_skid2 and jit_demux.
// Contents: JIT_DW          default tdata width
//           JIT_CONF_W      width of the destination select field
//           JIT_CONF_OFF    select value meaning "disconnected"
//           JIT_MAX_PORTS   number of physical destination ports
//           jitBeat_t       one stream beat at the default width
//           jitConfEff()    maps a raw select onto a populated port or OFF

package jit_pkg;

    localparam int JIT_DW        = 32;
    localparam int JIT_CONF_W    = 4;
    localparam logic [JIT_CONF_W-1:0] JIT_CONF_OFF = '0;
    localparam int JIT_MAX_PORTS = 8;

    typedef logic [JIT_DW-1:0] jitBeat_t;

    // Anything that does not name a populated port collapses to OFF, so
    // out-of-range selects behave exactly like an explicit disconnect.
    function automatic logic [JIT_CONF_W-1:0] jitConfEff(
        input logic [JIT_CONF_W-1:0] conf,
        input int                    num
    );
        if ((conf != JIT_CONF_OFF) && (32'(conf) <= 32'(num))) begin
            return conf;
        end
        return JIT_CONF_OFF;
    endfunction

endpackage

// File: rtl/jit_skid2.sv
// rtl/jit_skid2.sv - two-entry registered FIFO holding beats on their way out
//
// Purpose : buffers up to two beats so the output is fully registered while
//           still sustaining one beat per cycle.
// Ports   : clk, rst       clock, synchronous active-high reset
//           push, pushData write a beat at the tail (ignored when full)
//           pop            drop the head beat (ignored when empty)
//           headData       current head beat
//           count          occupancy 0..2
//           countNext      occupancy after this cycle's push/pop

module jit_skid2
    import jit_pkg::*;
#(
    parameter int DW = JIT_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] pushData,
    input  logic          pop,
    output logic [DW-1:0] headData,
    output logic [1:0]    count,
    output logic [1:0]    countNext
);

    logic [DW-1:0] mem [2];
    logic          headPtr;
    logic          tailPtr;
    logic          doPush;
    logic          doPop;

    always_comb begin
        doPush    = push && (count != 2'd2);
        doPop     = pop && (count != 2'd0);
        // Tail sits one slot past the head only when exactly one beat is held.
        tailPtr   = headPtr ^ count[0];
        headData  = mem[headPtr];
        countNext = count;
        if (doPush && !doPop) begin
            countNext = count + 2'd1;
        end else if (doPop && !doPush) begin
            countNext = count - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem     <= '{default: '0};
            headPtr <= 1'b0;
            count   <= 2'd0;
        end else begin
            if (doPush) begin
                mem[tailPtr] <= pushData;
            end
            if (doPop) begin
                headPtr <= ~headPtr;
            end
            count <= countNext;
        end
    end

endmodule

// File: rtl/jit_demux.sv
// rtl/jit_demux.sv - 1-to-8 stream router with drain-before-switch destination select
//
// Purpose : steers one input stream to the output selected by CONF through a
//           two-entry registered buffer; a new selection only takes effect
//           once every buffered beat has left on the old destination.
// Ports   : ACLK, ARESET                 clock, synchronous active-high reset
//           sIn_tvalid/tready/tdata      input stream
//           mK_tvalid/tready/tdata       output streams, K = 1..8 (K > NUM tied off)
//           CONF                         destination select, 0 = disconnected
//           BUSY                         buffer non-empty or switch pending

module jit_demux
    import jit_pkg::*;
#(
    parameter int NUM = 2,
    parameter int DW  = JIT_DW
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    output logic                  sIn_tready,
    input  logic                  sIn_tvalid,
    input  logic [DW-1:0]         sIn_tdata,
    input  logic                  m1_tready,
    input  logic                  m2_tready,
    input  logic                  m3_tready,
    input  logic                  m4_tready,
    input  logic                  m5_tready,
    input  logic                  m6_tready,
    input  logic                  m7_tready,
    input  logic                  m8_tready,
    output logic                  m1_tvalid,
    output logic                  m2_tvalid,
    output logic                  m3_tvalid,
    output logic                  m4_tvalid,
    output logic                  m5_tvalid,
    output logic                  m6_tvalid,
    output logic                  m7_tvalid,
    output logic                  m8_tvalid,
    output logic [DW-1:0]         m1_tdata,
    output logic [DW-1:0]         m2_tdata,
    output logic [DW-1:0]         m3_tdata,
    output logic [DW-1:0]         m4_tdata,
    output logic [DW-1:0]         m5_tdata,
    output logic [DW-1:0]         m6_tdata,
    output logic [DW-1:0]         m7_tdata,
    output logic [DW-1:0]         m8_tdata,
    input  logic [JIT_CONF_W-1:0] CONF,
    output logic                  BUSY
);

    logic [JIT_CONF_W-1:0]  confEff;
    logic [JIT_CONF_W-1:0]  selQ;
    logic [JIT_MAX_PORTS:1] mReady;
    logic [JIT_MAX_PORTS:1] mValid;
    logic [DW-1:0]          mData [1:JIT_MAX_PORTS];
    logic                   selReady;
    logic                   push;
    logic                   pop;
    logic [DW-1:0]          headData;
    logic [1:0]             count;
    logic [1:0]             countNext;

    assign mReady = {m8_tready, m7_tready, m6_tready, m5_tready,
                     m4_tready, m3_tready, m2_tready, m1_tready};

    assign confEff = jitConfEff(CONF, NUM);

    // Ready drops as soon as CONF disagrees with the latched selection, so
    // the old destination drains while the new one waits.
    assign sIn_tready = (count != 2'd2) && (selQ != JIT_CONF_OFF) && (confEff == selQ);
    assign push       = sIn_tvalid && sIn_tready;
    assign pop        = (count != 2'd0) && selReady;
    assign BUSY       = (count != 2'd0) || (confEff != selQ);

    always_comb begin
        selReady = 1'b0;
        for (int k = 1; k <= JIT_MAX_PORTS; k++) begin
            mValid[k] = 1'b0;
            mData[k]  = '0;
            if ((k <= NUM) && (selQ == JIT_CONF_W'(k))) begin
                selReady  = mReady[k];
                mValid[k] = (count != 2'd0);
                mData[k]  = headData;
            end
        end
    end

    jit_skid2 #(
        .DW (DW)
    ) uSkid (
        .clk       (ACLK),
        .rst       (ARESET),
        .push      (push),
        .pushData  (sIn_tdata),
        .pop       (pop),
        .headData  (headData),
        .count     (count),
        .countNext (countNext)
    );

    // Switching only when the buffer ends the cycle empty guarantees every
    // beat leaves on the destination that was selected when it was accepted.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            selQ <= JIT_CONF_OFF;
        end else if (countNext == 2'd0) begin
            selQ <= confEff;
        end
    end

    assign m1_tvalid = mValid[1];
    assign m2_tvalid = mValid[2];
    assign m3_tvalid = mValid[3];
    assign m4_tvalid = mValid[4];
    assign m5_tvalid = mValid[5];
    assign m6_tvalid = mValid[6];
    assign m7_tvalid = mValid[7];
    assign m8_tvalid = mValid[8];
    assign m1_tdata  = mData[1];
    assign m2_tdata  = mData[2];
    assign m3_tdata  = mData[3];
    assign m4_tdata  = mData[4];
    assign m5_tdata  = mData[5];
    assign m6_tdata  = mData[6];
    assign m7_tdata  = mData[7];
    assign m8_tdata  = mData[8];

endmodule

// File: tb/tb_jit_demux.sv
// tb/tb_jit_demux.sv - self-checking bench for jit_demux against a queue-based model

module tb_jit_demux;
    import jit_pkg::*;

    localparam int NUM = 2;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        sIn_tready;
    logic        sIn_tvalid;
    jitBeat_t    sIn_tdata;
    logic        m1_tready, m2_tready, m3_tready, m4_tready;
    logic        m5_tready, m6_tready, m7_tready, m8_tready;
    logic        m1_tvalid, m2_tvalid, m3_tvalid, m4_tvalid;
    logic        m5_tvalid, m6_tvalid, m7_tvalid, m8_tvalid;
    jitBeat_t    m1_tdata, m2_tdata, m3_tdata, m4_tdata;
    jitBeat_t    m5_tdata, m6_tdata, m7_tdata, m8_tdata;
    logic [3:0]  CONF;
    logic        BUSY;

    always #5 ACLK = ~ACLK;

    jit_demux #(.NUM(NUM), .DW(JIT_DW)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .sIn_tready(sIn_tready), .sIn_tvalid(sIn_tvalid), .sIn_tdata(sIn_tdata),
        .m1_tready(m1_tready), .m2_tready(m2_tready), .m3_tready(m3_tready), .m4_tready(m4_tready),
        .m5_tready(m5_tready), .m6_tready(m6_tready), .m7_tready(m7_tready), .m8_tready(m8_tready),
        .m1_tvalid(m1_tvalid), .m2_tvalid(m2_tvalid), .m3_tvalid(m3_tvalid), .m4_tvalid(m4_tvalid),
        .m5_tvalid(m5_tvalid), .m6_tvalid(m6_tvalid), .m7_tvalid(m7_tvalid), .m8_tvalid(m8_tvalid),
        .m1_tdata(m1_tdata), .m2_tdata(m2_tdata), .m3_tdata(m3_tdata), .m4_tdata(m4_tdata),
        .m5_tdata(m5_tdata), .m6_tdata(m6_tdata), .m7_tdata(m7_tdata), .m8_tdata(m8_tdata),
        .CONF(CONF), .BUSY(BUSY)
    );

    wire [8:1] vV = {m8_tvalid, m7_tvalid, m6_tvalid, m5_tvalid, m4_tvalid, m3_tvalid, m2_tvalid, m1_tvalid};
    wire [8:1] tR = {m8_tready, m7_tready, m6_tready, m5_tready, m4_tready, m3_tready, m2_tready, m1_tready};
    jitBeat_t vD [1:8];
    assign vD[1] = m1_tdata; assign vD[2] = m2_tdata; assign vD[3] = m3_tdata; assign vD[4] = m4_tdata;
    assign vD[5] = m5_tdata; assign vD[6] = m6_tdata; assign vD[7] = m7_tdata; assign vD[8] = m8_tdata;

    int       vectors = 0;
    int       errors  = 0;
    bit       armed   = 0;

    jitBeat_t mq [$];
    int       mSel = 0;
    jitBeat_t rcv1 [$];
    jitBeat_t rcv2 [$];
    int       rcvOther = 0;
    bit       prevHold = 0;
    int       prevK = 0;
    jitBeat_t prevData = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic int effOf(input logic [3:0] c);
        if (c >= 4'd1 && 32'(c) <= NUM) return int'(c);
        return 0;
    endfunction

    function automatic bit readyOf(input int k);
        if (k < 1 || k > 8) return 1'b0;
        return tR[k];
    endfunction

    // Reference: a queue of accepted beats plus the destination they belong to.
    always @(posedge ACLK) begin
        if (ARESET) begin
            mq.delete();
            mSel = 0;
            prevHold = 0;
        end else begin
            int  eff;
            bit  rdy, pushB, popB;
            eff   = effOf(CONF);
            rdy   = (mq.size() < 2) && (mSel != 0) && (eff == mSel);
            pushB = sIn_tvalid && rdy;
            popB  = (mq.size() > 0) && readyOf(mSel);
            if (popB) void'(mq.pop_front());
            if (pushB) mq.push_back(sIn_tdata);
            if (mq.size() == 0) mSel = eff;
        end
    end

    always @(negedge ACLK) begin
        if (armed && !ARESET) begin
            int eff;
            bit expV;
            eff = effOf(CONF);
            chk("sIn_tready", 32'(sIn_tready), 32'((mq.size() < 2) && (mSel != 0) && (eff == mSel)));
            chk("BUSY", 32'(BUSY), 32'((mq.size() > 0) || (eff != mSel)));
            if (prevHold) begin
                chk("hold_valid", 32'(vV[prevK]), 32'd1);
                chk("hold_data", vD[prevK], prevData);
            end
            for (int k = 1; k <= 8; k++) begin
                expV = (k == mSel) && (mq.size() > 0);
                chk($sformatf("m%0d_tvalid", k), 32'(vV[k]), 32'(expV));
                if (k != mSel) chk($sformatf("m%0d_tdata_idle", k), vD[k], 32'd0);
                else if (expV) chk($sformatf("m%0d_tdata", k), vD[k], mq[0]);
            end
            prevHold = 0;
            for (int k = 1; k <= 8; k++) begin
                if (vV[k] && !tR[k]) begin
                    prevHold = 1; prevK = k; prevData = vD[k];
                end
                if (vV[k] && tR[k]) begin
                    if (k == 1) rcv1.push_back(vD[k]);
                    else if (k == 2) rcv2.push_back(vD[k]);
                    else rcvOther++;
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge ACLK); #1; end
    endtask

    task automatic sendBeat(input jitBeat_t d, input int budget);
        bit hs;
        hs = 0;
        sIn_tvalid = 1'b1;
        sIn_tdata  = d;
        for (int i = 0; i < budget && !hs; i++) begin
            @(negedge ACLK);
            hs = sIn_tready;
            @(posedge ACLK); #1;
        end
        if (!hs) begin
            vectors++; errors++;
            $display("FAIL send_timeout: beat %h not accepted within %0d cycles", d, budget);
        end
    endtask

    task automatic clearLogs();
        rcv1.delete(); rcv2.delete(); rcvOther = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors + 1);
        $fatal(1);
    end

    initial begin
        ARESET = 1'b1; sIn_tvalid = 1'b0; sIn_tdata = '0; CONF = 4'd0;
        m1_tready = 1'b0; m2_tready = 1'b0;
        m3_tready = 1'b1; m4_tready = 1'b1; m5_tready = 1'b1;
        m6_tready = 1'b1; m7_tready = 1'b1; m8_tready = 1'b1;
        cyc(3);
        ARESET = 1'b0;
        armed = 1;
        @(negedge ACLK);
        chk("rst_tready", 32'(sIn_tready), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_valids", 32'(vV), 32'd0);
        for (int k = 1; k <= 8; k++) chk("rst_tdata", vD[k], 32'd0);
        @(posedge ACLK); #1;

        // 1: back-to-back A0..A3 to m1, one-cycle latency, full throughput
        clearLogs();
        CONF = 4'd1; m1_tready = 1'b1; m2_tready = 1'b1;
        cyc(2);
        sIn_tvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sIn_tdata = 32'hA0 + 32'(i);
            @(negedge ACLK);
            chk("t1_ready", 32'(sIn_tready), 32'd1);
            if (i > 0) begin
                chk("t1_valid", 32'(m1_tvalid), 32'd1);
                chk("t1_data", m1_tdata, 32'hA0 + 32'(i - 1));
            end
            @(posedge ACLK); #1;
        end
        sIn_tvalid = 1'b0;
        @(negedge ACLK);
        chk("t1_last", m1_tdata, 32'hA3);
        cyc(3);
        chk("t1_count", 32'(rcv1.size()), 32'd4);
        for (int i = 0; i < rcv1.size(); i++) chk("t1_seq", rcv1[i], 32'hA0 + 32'(i));
        chk("t1_m2_quiet", 32'(rcv2.size()), 32'd0);

        // 2: fill under backpressure on m2, then release
        clearLogs();
        CONF = 4'd2; m2_tready = 1'b0;
        sendBeat(32'hB0, 10);
        sendBeat(32'hB1, 10);
        sIn_tdata = 32'hB2;
        cyc(3);
        @(negedge ACLK);
        chk("t2_full_ready", 32'(sIn_tready), 32'd0);
        chk("t2_busy", 32'(BUSY), 32'd1);
        chk("t2_head", m2_tdata, 32'hB0);
        @(posedge ACLK); #1;
        m2_tready = 1'b1;
        sendBeat(32'hB2, 10);
        sIn_tvalid = 1'b0;
        cyc(5);
        chk("t2_count", 32'(rcv2.size()), 32'd3);
        for (int i = 0; i < rcv2.size(); i++) chk("t2_seq", rcv2[i], 32'hB0 + 32'(i));

        // 3: switch while m1 holds two beats
        clearLogs();
        CONF = 4'd1; m1_tready = 1'b0; m2_tready = 1'b0;
        sendBeat(32'hC0, 10);
        sendBeat(32'hC1, 10);
        sIn_tvalid = 1'b0;
        CONF = 4'd2;
        @(negedge ACLK);
        chk("t3_ready", 32'(sIn_tready), 32'd0);
        chk("t3_busy", 32'(BUSY), 32'd1);
        @(posedge ACLK); #1;
        m1_tready = 1'b1; m2_tready = 1'b1;
        sendBeat(32'hC2, 10);
        sIn_tvalid = 1'b0;
        cyc(4);
        chk("t3_m1_count", 32'(rcv1.size()), 32'd2);
        if (rcv1.size() == 2) begin
            chk("t3_m1_c0", rcv1[0], 32'hC0);
            chk("t3_m1_c1", rcv1[1], 32'hC1);
        end
        chk("t3_m2_count", 32'(rcv2.size()), 32'd1);
        if (rcv2.size() == 1) chk("t3_m2_c2", rcv2[0], 32'hC2);

        // 4: out-of-range select, then disconnect: nothing consumed
        clearLogs();
        sIn_tvalid = 1'b1; sIn_tdata = 32'hEE;
        for (int phase = 0; phase < 2; phase++) begin
            CONF = (phase == 0) ? 4'd5 : 4'd0;
            cyc(1);
            for (int i = 0; i < 4; i++) begin
                @(negedge ACLK);
                chk("t4_ready", 32'(sIn_tready), 32'd0);
                chk("t4_valids", 32'(vV), 32'd0);
                @(posedge ACLK); #1;
            end
        end
        sIn_tvalid = 1'b0;
        chk("t4_consumed", 32'(rcv1.size() + rcv2.size() + rcvOther), 32'd0);

        // 5: reset with two beats buffered
        CONF = 4'd1; m1_tready = 1'b0;
        cyc(1);
        sendBeat(32'hD8, 10);
        sendBeat(32'hD9, 10);
        sIn_tvalid = 1'b0;
        @(negedge ACLK);
        chk("t5_pre_valid", 32'(m1_tvalid), 32'd1);
        @(posedge ACLK); #1;
        ARESET = 1'b1;
        cyc(1);
        ARESET = 1'b0;
        @(negedge ACLK);
        chk("t5_post_valids", 32'(vV), 32'd0);
        chk("t5_post_busy", 32'(BUSY), 32'd1);
        @(posedge ACLK); #1;
        clearLogs();
        m1_tready = 1'b1;
        sendBeat(32'hD0, 10);
        sIn_tvalid = 1'b0;
        cyc(4);
        chk("t5_count", 32'(rcv1.size()), 32'd1);
        if (rcv1.size() == 1) chk("t5_d0", rcv1[0], 32'hD0);

        // 6: random backpressure on m1 over 100 incrementing beats
        clearLogs();
        CONF = 4'd1;
        begin
            bit done;
            done = 0;
            fork
                begin
                    for (int i = 0; i < 100; i++) sendBeat(32'h100 + 32'(i), 60);
                    sIn_tvalid = 1'b0;
                    done = 1;
                end
                begin
                    while (!done) begin
                        @(posedge ACLK); #1;
                        m1_tready = 1'($urandom_range(0, 1));
                    end
                end
            join
        end
        m1_tready = 1'b1;
        cyc(5);
        chk("t6_count", 32'(rcv1.size()), 32'd100);
        for (int i = 0; i < rcv1.size(); i++) chk("t6_seq", rcv1[i], 32'h100 + 32'(i));
        chk("t6_others", 32'(rcv2.size() + rcvOther), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
